mem_access_unit: RTL

Executes the data-memory side of load/store instructions using the Size, MemWrite, MemRead and lb_lh fields produced by the instruction decoder. Accepts one access from the pipeline and computes big-endian byte lanes. Runs a request/acknowledge transaction to data memory and returns the extended load data. Stalls the pipeline while busy. Reports misaligned or illegal accesses and memory timeouts as one-cycle pulses for the exception logic.

---
 rtl/mau_pkg.sv | 23 ++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/mem_access_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mau_pkg.sv
// Shared encodings for the data-memory access path: access sizes, FSM states and byte-enable patterns.
// The instruction decoder imports the size encodings from here.
package mau_pkg;
  localparam int NUM_LANES = 4;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [NUM_LANES-1:0] BE_NONE    = 4'b0000;
  localparam logic [NUM_LANES-1:0] BE_WORD    = 4'b1111;
  localparam logic [NUM_LANES-1:0] BE_HI_HALF = 4'b1100;
  localparam logic [NUM_LANES-1:0] BE_LO_HALF = 4'b0011;
  localparam logic [NUM_LANES-1:0] BE_BYTE0   = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_ERR
  } mau_state_e;
endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: byte enables and replicated store data for a write,
// lane select plus sign/zero extension for a load, and alignment legality.
module mem_lane_align
  import mau_pkg::*;
(
  input  logic [1:0]           size,
  input  logic [1:0]           offset,
  input  logic [31:0]          wdata,
  input  logic [31:0]          dm_rdata,
  input  logic                 sign_ext,
  output logic [NUM_LANES-1:0] be,
  output logic [31:0]          lane_wdata,
  output logic [31:0]          ext_rdata,
  output logic                 misalign
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // offset 0 is the most significant byte
    case (offset)
      2'd0:    byte_sel = dm_rdata[31:24];
      2'd1:    byte_sel = dm_rdata[23:16];
      2'd2:    byte_sel = dm_rdata[15:8];
      default: byte_sel = dm_rdata[7:0];
    endcase
    half_sel = offset[1] ? dm_rdata[15:0] : dm_rdata[31:16];
  end

  always_comb begin
    be         = BE_NONE;
    lane_wdata = '0;
    ext_rdata  = '0;
    misalign   = 1'b0;
    case (size)
      SZ_BYTE: begin
        be         = BE_BYTE0 >> offset;
        lane_wdata = {4{wdata[7:0]}};
        ext_rdata  = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be         = offset[1] ? BE_LO_HALF : BE_HI_HALF;
        lane_wdata = {2{wdata[15:0]}};
        ext_rdata  = {{16{sign_ext & half_sel[15]}}, half_sel};
        misalign   = offset[0];
      end
      SZ_WORD: begin
        be         = BE_WORD;
        lane_wdata = wdata;
        ext_rdata  = dm_rdata;
        misalign   = (offset != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store data-memory sequencer: one access at a time over a req/ack bus,
// stalls the pipeline while busy and pulses done, fault or bus_err on completion.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              fault,
  output logic              bus_err,
  output logic              dm_req,
  output logic              dm_we,
  output logic [3:0]        dm_be,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mau_state_e state, state_nxt;
  logic [1:0]       size_q, off_q;
  logic             rd_q, wr_q, sext_q, bus_err_q;
  logic [CNT_W-1:0] cnt;

  logic [1:0]           al_size, al_off;
  logic                 al_sext;
  logic [NUM_LANES-1:0] al_be;
  logic [31:0]          al_wdata, al_rdata;
  logic                 al_misalign;
  logic                 illegal, timeout;

  // In IDLE the aligner sees the incoming request; afterwards the captured one,
  // so the same instance serves both store steering and load extraction.
  assign al_size = (state == ST_IDLE) ? size      : size_q;
  assign al_off  = (state == ST_IDLE) ? addr[1:0] : off_q;
  assign al_sext = (state == ST_IDLE) ? sign_ext  : sext_q;

  mem_lane_align u_align (
    .size      (al_size),
    .offset    (al_off),
    .wdata     (wdata),
    .dm_rdata  (dm_rdata),
    .sign_ext  (al_sext),
    .be        (al_be),
    .lane_wdata(al_wdata),
    .ext_rdata (al_rdata),
    .misalign  (al_misalign)
  );

  assign illegal = al_misalign | (mem_read & mem_write);
  assign timeout = (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    fault     = 1'b0;
    bus_err   = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (illegal)                     state_nxt = ST_ERR;
          else if (mem_read || mem_write)  state_nxt = ST_REQ;
          else                             state_nxt = ST_RESP;
        end
      end
      ST_REQ: begin
        busy   = 1'b1;
        dm_req = 1'b1;
        dm_we  = wr_q;
        if (dm_ack)       state_nxt = ST_RESP;
        else if (timeout) state_nxt = ST_ERR;
      end
      ST_RESP: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        busy      = 1'b1;
        fault     = ~bus_err_q;
        bus_err   = bus_err_q;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      size_q    <= SZ_WORD;
      off_q     <= 2'b00;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      sext_q    <= 1'b0;
      bus_err_q <= 1'b0;
      cnt       <= '0;
      rdata     <= '0;
      dm_be     <= BE_NONE;
      dm_addr   <= '0;
      dm_wdata  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        size_q    <= size;
        off_q     <= addr[1:0];
        rd_q      <= mem_read;
        wr_q      <= mem_write;
        sext_q    <= sign_ext;
        bus_err_q <= 1'b0;
        dm_be     <= al_be;
        dm_addr   <= {addr[ADDR_W-1:2], 2'b00};
        dm_wdata  <= al_wdata;
      end
      if (state == ST_REQ) begin
        if (dm_ack) begin
          cnt <= '0;
          if (rd_q) rdata <= al_rdata;
        end else if (timeout) begin
          cnt       <= '0;
          bus_err_q <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule
